// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the E stage and the HI/LO multiply-divide unit.
interface mult_div_unit_if;
    logic        start;
    logic        MD;
    logic [3:0]  MDCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] MDout;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, MD, MDCtrl, A, B, input busy, MDout, HI, LO);
    modport slave  (input start, MD, MDCtrl, A, B, output busy, MDout, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/multu/div/divu unit owning the architectural HI/LO registers.
// Optional MULT_DIV_UNIT_FLUSH_EN adds a flush input that aborts an in-flight op.
module mult_div_unit (
    input  logic clk,
    input  logic reset_n,
`ifdef MULT_DIV_UNIT_FLUSH_EN
    input  logic flush,
`endif
    mult_div_unit_if.slave bus
);
    localparam int unsigned W          = 32;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MUL_CYCLES = 5;
    localparam int unsigned DIV_CYCLES = 10;

    typedef enum logic { IDLE, BUSY } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic             flush_c;

`ifdef MULT_DIV_UNIT_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Datapath results from the latched operands, consumed at completion.
    logic signed [2*W-1:0] prod_s;
    logic        [2*W-1:0] prod_u;
    logic signed [W-1:0]   quot_s, rem_s;
    logic        [W-1:0]   quot_u, rem_u;
    logic                  div_ovf_c;

    assign prod_s    = $signed({{W{a_q[W-1]}}, a_q}) * $signed({{W{b_q[W-1]}}, b_q});
    assign prod_u    = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    assign quot_s    = $signed(a_q) / $signed(b_q);
    assign rem_s     = $signed(a_q) % $signed(b_q);
    assign quot_u    = a_q / b_q;
    assign rem_u     = a_q % b_q;
    // Most-negative / -1 overflows; pin the result rather than trust the divider.
    assign div_ovf_c = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (flush_c) begin
                    state_d = IDLE;
                end else if (bus.MD && bus.start && (bus.MDCtrl[3:2] == 2'b00)) begin
                    state_d = BUSY;
                    cnt_d   = bus.MDCtrl[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    op_d    = bus.MDCtrl[1:0];
                    a_d     = bus.A;
                    b_d     = bus.B;
                end else if (bus.MD && (bus.MDCtrl == 4'b0110)) begin
                    hi_d = bus.A;
                end else if (bus.MD && (bus.MDCtrl == 4'b0111)) begin
                    lo_d = bus.A;
                end
            end
            BUSY: begin
                if (flush_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        case (op_q)
                            2'b00: {hi_d, lo_d} = prod_s;
                            2'b01: {hi_d, lo_d} = prod_u;
                            2'b10: begin
                                if (b_q != '0) begin
                                    if (div_ovf_c) begin
                                        hi_d = '0;
                                        lo_d = 32'h8000_0000;
                                    end else begin
                                        hi_d = rem_s;
                                        lo_d = quot_s;
                                    end
                                end
                            end
                            default: begin
                                if (b_q != '0) begin
                                    hi_d = rem_u;
                                    lo_d = quot_u;
                                end
                            end
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = (state_q == BUSY);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.MDout = (bus.MDCtrl == 4'b0100) ? hi_q :
                       (bus.MDCtrl == 4'b0101) ? lo_q : '0;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected completions, a monitor checks them.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset_n;
    logic flush;

    mult_div_unit_if bus();

    mult_div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef MULT_DIV_UNIT_FLUSH_EN
        .flush   (flush),
`endif
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and checks HI/LO each time busy falls.
    initial begin
        int   run;
        logic prev;
        exp_t e;
        string n;
        run = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run = 0;
                prev = 1'b0;
            end else begin
                if (bus.busy) run++;
                else if (prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=completion expected=none");
                    end else begin
                        e = sb.pop_front();
                        n = nq.pop_front();
                        check({n, "_cycles"}, 32'(run), e.cycles);
                        check({n, "_hi"}, bus.HI, e.hi);
                        check({n, "_lo"}, bus.LO, e.lo);
                    end
                    run = 0;
                end
                prev = bus.busy;
            end
        end
    end

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.MD     = 1'b0;
        bus.MDCtrl = 4'b0000;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input int cyc, input logic [31:0] ehi,
                         input logic [31:0] elo, input string name);
        exp_t e;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.MD = 1'b1; bus.MDCtrl = op; bus.A = a; bus.B = b;
        if (push) begin
            e.cycles = 32'(cyc); e.hi = ehi; e.lo = elo;
            sb.push_back(e);
            nq.push_back(name);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout actual=busy expected=idle", name);
        end
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        bus.MD = 1'b1; bus.MDCtrl = op; bus.A = v;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic move_from(input logic [3:0] op, input logic [31:0] exp, input string name);
        bus.MD = 1'b1; bus.MDCtrl = op;
        #1;
        check(name, bus.MDout, exp);
        bus.MD = 1'b0; bus.MDCtrl = 4'b0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        idle_inputs();
        bus.A = '0; bus.B = '0;
        bus.MDCtrl = 4'b0100;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_mdout", bus.MDout, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.MDCtrl = 4'b0000;

        issue(4'b0000, 32'hFFFF_FFFE, 32'd3, 1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        wait_done("mult");
        issue(4'b0001, 32'hFFFF_FFFE, 32'd3, 1, 5, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
        wait_done("multu");
        issue(4'b0010, 32'hFFFF_FFF9, 32'd2, 1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        wait_done("div");
        issue(4'b0011, 32'd7, 32'd0, 1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_by0");
        wait_done("divu_by0");
        issue(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 10, 32'h0, 32'h8000_0000, "div_ovf");
        wait_done("div_ovf");
        issue(4'b0011, 32'd100, 32'd7, 1, 10, 32'd2, 32'd14, "divu");
        wait_done("divu");
        issue(4'b0000, 32'h8000_0000, 32'h8000_0000, 1, 5, 32'h4000_0000, 32'h0, "mult_min");
        wait_done("mult_min");

        move_to(4'b0110, 32'h1234_5678);
        move_from(4'b0100, 32'h1234_5678, "mfhi");
        move_to(4'b0111, 32'hCAFE_F00D);
        move_from(4'b0101, 32'hCAFE_F00D, "mflo");

        // mf during busy sees old values; mtlo during busy is dropped
        issue(4'b0000, 32'd5, 32'd6, 1, 5, 32'h0, 32'd30, "mult_mtlo");
        move_from(4'b0100, 32'h1234_5678, "mfhi_busy");
        move_from(4'b0101, 32'hCAFE_F00D, "mflo_busy");
        bus.MD = 1'b1; bus.MDCtrl = 4'b0111; bus.A = 32'h0000_DEAD;
        @(posedge clk); #1;
        idle_inputs();
        wait_done("mult_mtlo");
        move_from(4'b0101, 32'd30, "mflo_after");

        // start of a mult during the busy window of a div is ignored
        issue(4'b0010, 32'd100, 32'hFFFF_FFF9, 1, 10, 32'd2, 32'hFFFF_FFF2, "div_restart");
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.MD = 1'b1; bus.MDCtrl = 4'b0000; bus.A = 32'h10; bus.B = 32'h10;
        @(posedge clk); #1;
        idle_inputs();
        wait_done("div_restart");

        // starts with a non-arithmetic code or MD low never launch
        @(posedge clk); #1;
        bus.start = 1'b1; bus.MD = 1'b1; bus.MDCtrl = 4'b0100;
        @(posedge clk); #1;
        bus.MDCtrl = 4'b1000;
        @(posedge clk); #1;
        bus.MD = 1'b0; bus.MDCtrl = 4'b0000;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("ignored_busy", 32'(bus.busy), 32'd0);
        check("ignored_hi", bus.HI, 32'd2);
        check("ignored_lo", bus.LO, 32'hFFFF_FFF2);

        // asynchronous reset in busy cycle 3 of a mult
        issue(4'b0000, 32'd3, 32'd3, 0, 0, 32'h0, 32'h0, "mult_rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_hi", bus.HI, 32'd0);
        check("midrst_lo", bus.LO, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_busy", 32'(bus.busy), 32'd0);
        check("postrst_hi", bus.HI, 32'd0);
        check("postrst_lo", bus.LO, 32'd0);

`ifdef MULT_DIV_UNIT_FLUSH_EN
        move_to(4'b0110, 32'hA);
        move_to(4'b0111, 32'hB);
        issue(4'b0010, 32'd20, 32'd3, 1, 4, 32'hA, 32'hB, "div_flush");
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(bus.busy), 32'd0);
        repeat (12) @(negedge clk);
        check("flush_hi_late", bus.HI, 32'hA);
        check("flush_lo_late", bus.LO, 32'hB);
`endif

        repeat (3) @(negedge clk);
        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: begins mult/multu/div/divu in E stage.
REQ-004 SHALL have port MD, input, 1 bit: E-stage instruction is any mult/div/mf/mt op.
REQ-005 SHALL have port MDCtrl, input, 4 bits: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mfhi, 0101 mflo, 0110 mthi, 0111 mtlo; others are no-op.
REQ-006 SHALL have port A, input, 32 bits: forwarded rs value.
REQ-007 SHALL have port B, input, 32 bits: forwarded rt value.
REQ-008 SHALL have port busy, output, 1 bit: operation in flight.
REQ-009 SHALL have port MDout, output, 32 bits: HI for 0100, LO for 0101, else 0.
REQ-010 SHALL have port HI, output, 32 bits: architectural HI register.
REQ-011 SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-012 SHALL use a two-state FSM: IDLE, BUSY; busy = (state == BUSY).
REQ-013 SHALL accept an op only when MD=1, start=1, MDCtrl[3:2]=00 and state=IDLE; it latches A, B and MDCtrl[1:0] on that edge.
REQ-014 SHALL load a down-counter on accept: 5 for mult/multu, 10 for div/divu; busy is 0 in the start cycle and 1 for exactly that many following cycles.
REQ-015 SHALL write HI/LO and return to IDLE on the edge at which the counter expires; new values are visible in the first cycle with busy=0.
REQ-016 SHALL compute mult as signed 64-bit and multu as unsigned 64-bit: HI=[63:32], LO=[31:0].
REQ-017 SHALL compute div/divu as: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend; divu is unsigned.
REQ-018 SHALL leave HI and LO unchanged at completion when divisor B=0; busy timing is unchanged.
REQ-019 SHALL return LO=0x80000000 and HI=0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-020 SHALL ignore start asserted while BUSY; no restart, counter and latched operands untouched.
REQ-021 SHALL write mthi/mtlo (MD=1, MDCtrl 0110/0111) from A on the edge only when IDLE; ignored while BUSY.
REQ-022 SHALL drive MDout combinationally from current HI/LO, returning pre-operation values while BUSY.
REQ-023 SHALL ignore start when MDCtrl[2]=1; MD=0 makes MDCtrl don't-care.

Reset
REQ-024 SHALL, on reset_n low at any time including mid-operation, immediately force state=IDLE, counter=0, busy=0, HI=0, LO=0 and latched operands to 0.
REQ-025 SHALL keep this state until the first rising clk edge after reset_n rises.

Configuration
REQ-026 SHALL provide macro MULT_DIV_UNIT_FLUSH_EN.
REQ-027 SHALL, with MULT_DIV_UNIT_FLUSH_EN defined, add input flush (1 bit, after reset_n): flush=1 at an edge forces IDLE and busy=0 next cycle, leaves HI/LO unchanged, and overrides start, mthi and mtlo in the same cycle.
REQ-028 SHALL, without MULT_DIV_UNIT_FLUSH_EN, omit the flush port; operations always run to completion.

Verification
REQ-029 SHALL cover mult A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 SHALL cover div A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10 busy cycles.
REQ-031 SHALL cover mthi A=0x12345678 while IDLE, then mfhi -> MDout=0x12345678 next cycle; mtlo during BUSY -> LO keeps completion value.
REQ-032 SHALL cover start mult during BUSY of a div -> only the div result is written, busy falls after the original 10 cycles.
REQ-033 SHALL cover reset_n pulsed low at busy cycle 3 of mult -> busy=0, HI=LO=0 immediately, no later write.
REQ-034 SHALL cover, with MULT_DIV_UNIT_FLUSH_EN, flush at busy cycle 4 of div with prior HI=0xA, LO=0xB -> busy=0 next cycle, HI=0xA, LO=0xB retained.
